fpnew_classify_arbiter: RTL and testbench

// - Shares one FP classification datapath among NumReq requesters. Arbitration is round-robin.
// - Each accepted request is classified, along with its fclass mask, and held in a single

---
 rtl/fpnew_classify_arbiter.sv | 162 ++++++++++++++++
 tb/tb_fpnew_classify_arbiter.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fpnew_classify_arbiter.sv
// Round-robin shared FP classifier: N requesters compete for one classification
// datapath whose result (fp_info bits, fclass mask, requester id) sits in a single
// output register with a valid/ready handshake.
// out_info_o bit order, MSB first: is_normal, is_subnormal, is_zero, is_inf,
// is_nan, is_signalling, is_quiet, is_boxed.
module fpnew_classify_arbiter #(
    parameter int unsigned FpFormat = 0,
    parameter int unsigned NumReq   = 4,
    localparam int unsigned EXP_BITS = (FpFormat == 1) ? 11 :
                                       (FpFormat == 2) ? 5  :
                                       (FpFormat == 3) ? 5  : 8,
    localparam int unsigned MAN_BITS = (FpFormat == 1) ? 52 :
                                       (FpFormat == 2) ? 10 :
                                       (FpFormat == 3) ? 2  :
                                       (FpFormat == 4) ? 7  : 23,
    localparam int unsigned WIDTH    = 1 + EXP_BITS + MAN_BITS,
    localparam int unsigned IDX_W    = (NumReq > 1) ? $clog2(NumReq) : 1
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    flush_i,
    input  logic [NumReq-1:0]       in_valid_i,
    output logic [NumReq-1:0]       in_ready_o,
    input  logic [NumReq*WIDTH-1:0] operand_i,
    input  logic [NumReq-1:0]       is_boxed_i,
    output logic                    out_valid_o,
    input  logic                    out_ready_i,
    output logic [7:0]              out_info_o,
    output logic [9:0]              out_class_o,
    output logic [IDX_W-1:0]        out_req_id_o
);

    // Bit k set when no request is pending in rotated positions 0..k-1.
    function automatic logic [NumReq-1:0] rot_idle(input logic [NumReq-1:0] v);
        logic [NumReq-1:0] res;
        logic              seen;
        res  = '0;
        seen = 1'b0;
        for (int k = 0; k < NumReq; k++) begin
            res[k] = !seen;
            seen   = seen | v[k];
        end
        return res;
    endfunction

    // Lowest set position in the rotated request vector (0 when empty).
    function automatic int rot_first(input logic [NumReq-1:0] v);
        int res;
        res = 0;
        for (int k = NumReq - 1; k >= 0; k--) begin
            if (v[k]) res = k;
        end
        return res;
    endfunction

    logic [IDX_W-1:0]    r_ptr;
    logic                r_valid;
    logic [7:0]          r_info;
    logic [9:0]          r_class;
    logic [IDX_W-1:0]    r_id;

    logic                w_accept;
    logic [NumReq-1:0]   w_rot;
    logic [NumReq-1:0]   w_rot_ready;
    logic [IDX_W-1:0]    w_gidx;
    logic [IDX_W-1:0]    w_ptr_nxt;
    logic                w_hs;
    logic [WIDTH-1:0]    w_op;
    logic                w_boxed;
    logic                w_sign;
    logic [EXP_BITS-1:0] w_exp;
    logic [MAN_BITS-1:0] w_man;
    logic                w_is_normal, w_is_subnormal, w_is_zero, w_is_inf;
    logic                w_is_nan, w_is_signalling, w_is_quiet;
    logic [7:0]          w_info;
    logic [9:0]          w_class;

    // Round-robin arbitration: rotate requests so the pointer sits at position 0.
    // A requester is offered ready when everyone ahead of it in round-robin order is
    // idle, so its ready never looks at its own valid; only one valid requester can
    // ever see ready at a time.
    always_comb begin
        // NOTE: every signal driven here gets a default first so no latch is inferred.
        w_accept    = !r_valid || out_ready_i;
        w_rot       = NumReq'({in_valid_i, in_valid_i} >> r_ptr);
        w_rot_ready = rot_idle(w_rot) & {NumReq{w_accept && !flush_i && !rst_i}};
        in_ready_o  = NumReq'({w_rot_ready, w_rot_ready} << r_ptr >> NumReq);
        w_gidx      = IDX_W'((int'(r_ptr) + rot_first(w_rot)) % int'(NumReq));
        w_ptr_nxt   = (w_gidx == IDX_W'(NumReq - 1)) ? '0 : w_gidx + 1'b1;
        w_hs        = |(in_valid_i & in_ready_o);
    end

    // Operand and NaN-box flag of the granted requester.
    always_comb begin
        w_op    = operand_i[WIDTH-1:0];
        w_boxed = is_boxed_i[0];
        for (int i = 1; i < NumReq; i++) begin
            if (w_gidx == IDX_W'(i)) begin
                w_op    = operand_i[i*WIDTH +: WIDTH];
                w_boxed = is_boxed_i[i];
            end
        end
    end

    assign w_sign = w_op[WIDTH-1];
    assign w_exp  = w_op[WIDTH-2 -: EXP_BITS];
    assign w_man  = w_op[MAN_BITS-1:0];

    // Field decode; an operand that is not properly NaN-boxed reads as a quiet NaN.
    always_comb begin
        w_is_normal     = w_boxed && (w_exp != '0) && !(&w_exp);
        w_is_zero       = w_boxed && (w_exp == '0) && (w_man == '0);
        w_is_subnormal  = w_boxed && (w_exp == '0) && (w_man != '0);
        w_is_inf        = w_boxed && (&w_exp) && (w_man == '0);
        w_is_nan        = !w_boxed || ((&w_exp) && (w_man != '0));
        w_is_signalling = w_boxed && w_is_nan && !w_man[MAN_BITS-1];
        w_is_quiet      = w_is_nan && !w_is_signalling;
        w_info          = {w_is_normal, w_is_subnormal, w_is_zero, w_is_inf,
                           w_is_nan, w_is_signalling, w_is_quiet, w_boxed};
    end

    // RISC-V fclass one-hot mask; the sign is ignored for NaNs.
    always_comb begin
        w_class = '0;
        if (w_is_nan)            w_class[w_is_signalling ? 8 : 9] = 1'b1;
        else if (w_is_inf)       w_class[w_sign ? 0 : 7] = 1'b1;
        else if (w_is_normal)    w_class[w_sign ? 1 : 6] = 1'b1;
        else if (w_is_subnormal) w_class[w_sign ? 2 : 5] = 1'b1;
        else                     w_class[w_sign ? 3 : 4] = 1'b1;
    end

    // Output stage and round-robin pointer; reset beats flush, flush beats a load.
    always_ff @(posedge clk_i) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples pre-edge values regardless of statement order.
        if (rst_i) begin
            // NOTE: the data registers are reset too because their post-reset value
            // is visible on the outputs; flush only clears the valid bit.
            r_valid <= 1'b0;
            r_info  <= '0;
            r_class <= '0;
            r_id    <= '0;
            r_ptr   <= '0;
        end else if (flush_i) begin
            r_valid <= 1'b0;
        end else if (w_hs) begin
            r_valid <= 1'b1;
            r_info  <= w_info;
            r_class <= w_class;
            r_id    <= w_gidx;
            r_ptr   <= w_ptr_nxt;
        end else if (out_ready_i) begin
            r_valid <= 1'b0;
        end
    end

    assign out_valid_o  = r_valid;
    assign out_info_o   = r_info;
    assign out_class_o  = r_class;
    assign out_req_id_o = r_id;

endmodule

// File: tb/tb_fpnew_classify_arbiter.sv
// Self-checking bench for fpnew_classify_arbiter (FP32, 4 requesters).
// Expected results are pushed to a scoreboard at the accept edge and compared
// while the result sits in the output register.
module tb_fpnew_classify_arbiter;

    localparam int N = 4;

    typedef struct packed {
        logic [1:0] id;
        logic [9:0] cls;
        logic [7:0] info;
    } exp_t;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic          flush_i;
    logic [3:0]    in_valid_i;
    logic [3:0]    in_ready_o;
    logic [127:0]  operand_i;
    logic [3:0]    is_boxed_i;
    logic          out_valid_o;
    logic          out_ready_i;
    logic [7:0]    out_info_o;
    logic [9:0]    out_class_o;
    logic [1:0]    out_req_id_o;

    int   n_checks = 0;
    int   n_errors = 0;
    int   m_ptr    = 0;
    logic m_valid  = 1'b0;
    int   last_g   = -1;
    exp_t sb[$];

    fpnew_classify_arbiter #(.FpFormat(0), .NumReq(N)) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .flush_i      (flush_i),
        .in_valid_i   (in_valid_i),
        .in_ready_o   (in_ready_o),
        .operand_i    (operand_i),
        .is_boxed_i   (is_boxed_i),
        .out_valid_o  (out_valid_o),
        .out_ready_i  (out_ready_i),
        .out_info_o   (out_info_o),
        .out_class_o  (out_class_o),
        .out_req_id_o (out_req_id_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Reference FP32 classifier; info = {nrm,sub,zero,inf,nan,snan,qnan,boxed}.
    function automatic exp_t ref_model(input logic [31:0] v, input logic boxed, input int id);
        exp_t e;
        logic [7:0]  ex;
        logic [22:0] mn;
        ex   = v[30:23];
        mn   = v[22:0];
        e.id = 2'(id);
        if (!boxed) begin
            e.cls = 10'h200; e.info = 8'b0000_1010;
        end else if (ex == 8'hFF && mn != 0) begin
            if (mn[22]) begin e.cls = 10'h200; e.info = 8'b0000_1011; end
            else        begin e.cls = 10'h100; e.info = 8'b0000_1101; end
        end else if (ex == 8'hFF) begin
            e.cls = v[31] ? 10'h001 : 10'h080; e.info = 8'b0001_0001;
        end else if (ex != 0) begin
            e.cls = v[31] ? 10'h002 : 10'h040; e.info = 8'b1000_0001;
        end else if (mn != 0) begin
            e.cls = v[31] ? 10'h004 : 10'h020; e.info = 8'b0100_0001;
        end else begin
            e.cls = v[31] ? 10'h008 : 10'h010; e.info = 8'b0010_0001;
        end
        return e;
    endfunction

    // One clock: check outputs and grant at mid-cycle, then advance the model.
    task automatic cycle();
        logic       acc;
        logic [3:0] exp_hs;
        int         g;
        exp_t       f;
        #1;
        n_checks++;
        if (out_valid_o !== m_valid) begin
            n_errors++;
            $display("FAIL out_valid: got %b want %b", out_valid_o, m_valid);
        end
        if (m_valid) begin
            n_checks++;
            if (sb.size() == 0) begin
                n_errors++;
                $display("FAIL scoreboard: result present but nothing expected");
            end else begin
                f = sb[0];
                if (out_req_id_o !== f.id || out_class_o !== f.cls || out_info_o !== f.info) begin
                    n_errors++;
                    $display("FAIL result: got id=%0d cls=%h info=%b want id=%0d cls=%h info=%b",
                             out_req_id_o, out_class_o, out_info_o, f.id, f.cls, f.info);
                end
            end
        end
        acc    = !m_valid || out_ready_i;
        exp_hs = '0;
        g      = -1;
        if (!rst_i && !flush_i && acc) begin
            for (int k = 0; k < N; k++) begin
                if (g < 0 && in_valid_i[(m_ptr + k) % N]) g = (m_ptr + k) % N;
            end
        end
        if (g >= 0) exp_hs[g] = 1'b1;
        n_checks++;
        if ((in_valid_i & in_ready_o) !== exp_hs) begin
            n_errors++;
            $display("FAIL grant: got %b want %b (ptr %0d)", in_valid_i & in_ready_o, exp_hs, m_ptr);
        end
        if (rst_i || flush_i || !acc) begin
            n_checks++;
            if (in_ready_o !== 4'b0000) begin
                n_errors++;
                $display("FAIL ready_blocked: got %b want 0000", in_ready_o);
            end
        end
        last_g = g;
        if (g >= 0) sb.push_back(ref_model(operand_i[g*32 +: 32], is_boxed_i[g], g));
        @(posedge clk_i);
        if (rst_i) begin
            m_valid = 1'b0; m_ptr = 0; sb.delete();
        end else if (flush_i) begin
            m_valid = 1'b0; sb.delete();
        end else begin
            if (m_valid && out_ready_i) void'(sb.pop_front());
            m_valid = (g >= 0) || (m_valid && !out_ready_i);
            if (g >= 0) m_ptr = (g + 1) % N;
        end
        @(negedge clk_i);
    endtask

    task automatic set_req(input int idx, input logic [31:0] op, input logic boxed);
        operand_i[idx*32 +: 32] = op;
        is_boxed_i[idx]         = boxed;
    endtask

    // Hold one request until it is accepted (bounded wait).
    task automatic issue(input int idx, input logic [31:0] op, input logic boxed);
        logic done;
        done = 1'b0;
        set_req(idx, op, boxed);
        in_valid_i[idx] = 1'b1;
        for (int t = 0; t < 20 && !done; t++) begin
            cycle();
            if (last_g == idx) done = 1'b1;
        end
        in_valid_i[idx] = 1'b0;
        if (!done) begin
            n_checks++; n_errors++;
            $display("FAIL issue_timeout: req %0d never accepted", idx);
        end
    endtask

    function automatic logic [31:0] rand_op();
        logic [31:0] v;
        v = $urandom;
        if ($urandom_range(0, 3) == 0) v[30:23] = 8'hFF;
        else if ($urandom_range(0, 3) == 0) v[30:23] = 8'h00;
        return v;
    endfunction

    task automatic test_reset();
        rst_i = 1'b1; flush_i = 1'b0; in_valid_i = '0; out_ready_i = 1'b1;
        operand_i = '0; is_boxed_i = '1;
        @(posedge clk_i);
        @(negedge clk_i);
        cycle();
        rst_i = 1'b0;
        n_checks++;
        if ({out_valid_o, out_info_o, out_class_o, out_req_id_o} !== '0) begin
            n_errors++;
            $display("FAIL reset_outputs: got v=%b info=%h cls=%h id=%0d want all 0",
                     out_valid_o, out_info_o, out_class_o, out_req_id_o);
        end
    endtask

    task automatic test_first();
        out_ready_i = 1'b1;
        issue(0, 32'h3F80_0000, 1'b1);
        n_checks++;
        if (out_valid_o !== 1'b1 || out_class_o !== 10'h040 || out_req_id_o !== 2'd0 || out_info_o[7] !== 1'b1) begin
            n_errors++;
            $display("FAIL first_result: got v=%b cls=%h id=%0d info=%b want v=1 cls=040 id=0 normal",
                     out_valid_o, out_class_o, out_req_id_o, out_info_o);
        end
        cycle();
    endtask

    task automatic test_class_sweep();
        logic [31:0] ops [6] = '{32'hFF80_0000, 32'h8000_0001, 32'h0000_0000,
                                 32'h7F80_0001, 32'h7FC0_0000, 32'h1234_5678};
        logic [9:0]  cls [6] = '{10'h001, 10'h004, 10'h010, 10'h100, 10'h200, 10'h200};
        logic        bx  [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        for (int k = 0; k < 6; k++) begin
            issue(1, ops[k], bx[k]);
            n_checks++;
            if (out_class_o !== cls[k] || out_req_id_o !== 2'd1) begin
                n_errors++;
                $display("FAIL sweep_%0d: got cls=%h id=%0d want cls=%h id=1",
                         k, out_class_o, out_req_id_o, cls[k]);
            end
        end
        n_checks++;
        if (out_info_o[1] !== 1'b1 || out_info_o[0] !== 1'b0) begin
            n_errors++;
            $display("FAIL unboxed_info: got %b want is_quiet=1 is_boxed=0", out_info_o);
        end
        cycle();
    endtask

    task automatic test_fairness();
        int start;
        for (int i = 0; i < N; i++) set_req(i, rand_op(), $urandom_range(0, 7) != 0);
        in_valid_i  = 4'hF;
        out_ready_i = 1'b1;
        start       = m_ptr;
        for (int t = 0; t < 12; t++) begin
            cycle();
            n_checks++;
            if (last_g !== (start + t) % N) begin
                n_errors++;
                $display("FAIL fairness_%0d: got id %0d want %0d", t, last_g, (start + t) % N);
            end
            if (last_g >= 0) set_req(last_g, rand_op(), $urandom_range(0, 7) != 0);
        end
        in_valid_i = '0;
        cycle();
    endtask

    task automatic test_back_pressure();
        logic [21:0] snap;
        in_valid_i  = 4'hF;
        out_ready_i = 1'b1;
        cycle();
        out_ready_i = 1'b0;
        snap = {out_info_o, out_class_o, out_req_id_o, out_valid_o, in_ready_o != 0};
        for (int t = 0; t < 3; t++) begin
            cycle();
            n_checks++;
            if ({out_info_o, out_class_o, out_req_id_o, out_valid_o, in_ready_o != 0} !== {snap[21:1], 1'b0}) begin
                n_errors++;
                $display("FAIL stall_%0d: got %h want %h",
                         t, {out_info_o, out_class_o, out_req_id_o, out_valid_o, in_ready_o != 0}, {snap[21:1], 1'b0});
            end
        end
        out_ready_i = 1'b1;
        cycle();
        n_checks++;
        if (last_g < 0) begin
            n_errors++;
            $display("FAIL drain_refill: got no grant want grant on drain cycle");
        end
        in_valid_i = '0;
        cycle();
        cycle();
    endtask

    task automatic test_flush();
        int saved;
        in_valid_i  = 4'hF;
        out_ready_i = 1'b0;
        cycle();
        saved   = m_ptr;
        flush_i = 1'b1;
        cycle();
        flush_i = 1'b0;
        n_checks++;
        if (out_valid_o !== 1'b0) begin
            n_errors++;
            $display("FAIL flush_valid: got %b want 0", out_valid_o);
        end
        out_ready_i = 1'b1;
        cycle();
        n_checks++;
        if (last_g !== saved) begin
            n_errors++;
            $display("FAIL flush_pointer: got grant %0d want %0d", last_g, saved);
        end
        in_valid_i = '0;
        cycle();
        cycle();
    endtask

    task automatic test_reset_mid();
        out_ready_i = 1'b1;
        issue(0, 32'h4000_0000, 1'b1);
        issue(1, 32'hC000_0000, 1'b1);
        out_ready_i = 1'b0;
        in_valid_i  = 4'hF;
        rst_i       = 1'b1;
        cycle();
        rst_i = 1'b0;
        n_checks++;
        if (out_valid_o !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_mid_valid: got %b want 0", out_valid_o);
        end
        out_ready_i = 1'b1;
        cycle();
        n_checks++;
        if (last_g !== 0) begin
            n_errors++;
            $display("FAIL reset_mid_grant: got %0d want 0", last_g);
        end
        in_valid_i = '0;
        cycle();
        cycle();
    endtask

    initial begin
        test_reset();
        test_first();
        test_class_sweep();
        test_fairness();
        test_back_pressure();
        test_flush();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
